// File: rtl/reaction_timer_n_if.sv
// Reaction timer bus: start/stop inputs and the count, display and status outputs.
interface reaction_timer_n_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  w;
    logic                  Pushn;
    logic                  tick;
    logic                  LEDn;
    logic [4*DIGITS-1:0]   BCD;
    logic [7*DIGITS-1:0]   Digits;
    logic [4*DIGITS-1:0]   Best;
    logic                  Ovf;

    modport master (
        output w, Pushn,
        input  tick, LEDn, BCD, Digits, Best, Ovf
    );

    modport slave (
        input  w, Pushn,
        output tick, LEDn, BCD, Digits, Best, Ovf
    );
endinterface

// File: rtl/reaction_timer_n.sv
// Reaction timer: LED lights on start, a BCD counter advances once per divider
// tick until the stop button is pressed, and the count is shown on 7-seg digits.
// Optional best-time register enabled by defining REACTION_TIMER_N_BEST_TIME_EN.
module reaction_timer_n #(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned DIV_LOG2 = 3,
    parameter bit          SAT      = 1'b1
) (
    input  logic                Clock,
    input  logic                Reset,
    reaction_timer_n_if.slave   bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SEG_W = 7 * DIGITS;
    localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    logic [DIV_LOG2-1:0] div_q;
    logic [BCD_W-1:0]    bcd_q;
    logic                ovf_q;
    logic                led_n_q;

    logic                tick_c;
    logic                start_c;
    logic [BCD_W-1:0]    bcd_inc_c;
    logic                all_nines_c;
    logic                carry_c;
    logic [SEG_W-1:0]    digits_c;

    assign tick_c  = &div_q;
    assign start_c = bus.w & bus.Pushn;

    // Segment pattern a..g (MSB = a) for one BCD digit; non-BCD codes blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Decimal ripple increment; a carry out of the top digit means all-9s.
    always_comb begin
        bcd_inc_c = bcd_q;
        carry_c   = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry_c) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_inc_c[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry_c             = 1'b0;
                end
            end
        end
        all_nines_c = carry_c;
    end

    // Control FSM with divider, counter, overflow flag and LED as registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            div_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            led_n_q <= 1'b1;
        end else begin
            div_q <= div_q + DIV_LOG2'(1);
            case (state)
                IDLE, HOLD: begin
                    if (start_c) begin
                        state   <= RUN;
                        led_n_q <= 1'b0;
                        bcd_q   <= '0;
                        ovf_q   <= 1'b0;
                        div_q   <= '0;
                    end
                end
                RUN: begin
                    // Stop wins over a coincident tick so the shown time is frozen as-is.
                    if (!bus.Pushn) begin
                        state   <= HOLD;
                        led_n_q <= 1'b1;
                    end else if (tick_c) begin
                        if (all_nines_c) begin
                            ovf_q <= 1'b1;
                            bcd_q <= SAT ? NINES : '0;
                        end else begin
                            bcd_q <= bcd_inc_c;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    led_n_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef REACTION_TIMER_N_BEST_TIME_EN
    logic [BCD_W-1:0] best_q;

    // Packed BCD orders like binary, so a plain compare finds the smaller time.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            best_q <= NINES;
        end else if ((state == RUN) && !bus.Pushn && !ovf_q && (bcd_q < best_q)) begin
            best_q <= bcd_q;
        end
    end

    assign bus.Best = best_q;
`else
    assign bus.Best = NINES;
`endif

    // Seven-segment decode of every digit of the live count.
    always_comb begin
        digits_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digits_c[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
        end
    end

    assign bus.tick   = tick_c;
    assign bus.LEDn   = led_n_q;
    assign bus.BCD    = bcd_q;
    assign bus.Ovf    = ovf_q;
    assign bus.Digits = digits_c;

endmodule
